dht11_result_fmt: RTL and testbench

//   Downstream stage of the DHT11 controller. Captures each completed reading
//   (humidity/temperature words qualified by dht11_done/dht11_valid) and converts
//   the integer bytes to 3-digit BCD with a sequential double-dabble, one shift
//   per clock. Holds the last good values for the FND/UART display path and

---
 rtl/dht11_result_fmt.sv | 165 ++++++++++++++++
 tb/tb_dht11_result_fmt.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dht11_result_fmt.sv
// DHT11 result formatter: captures good readings, converts the integer bytes to
// 3-digit BCD by sequential double-dabble, and tracks read errors and staleness.
//
// state  | meaning
// IDLE   | waiting for a good reading
// CONV_H | 8 double-dabble iterations on the humidity byte
// CONV_T | 8 double-dabble iterations on the temperature byte
// COMMIT | publish results, then chain a pending reading or go idle
module dht11_result_fmt #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned STALE_SEC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        dht11_done,
    input  logic        dht11_valid,
    output logic [11:0] hum_bcd,
    output logic [11:0] temp_bcd,
    output logic [3:0]  temp_frac,
    output logic        disp_valid,
    output logic        upd_pulse,
    output logic        busy,
    output logic        stale,
    output logic [7:0]  err_cnt
);
    localparam logic [63:0] STALE_LIM = 64'(CLK_FREQ) * 64'(STALE_SEC);
    localparam int CNT_W = $clog2(STALE_LIM + 64'd1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STALE_LIM);

    typedef enum logic [1:0] {IDLE, CONV_H, CONV_T, COMMIT} state_t;

    state_t           state;
    logic [19:0]      dd;
    logic [19:0]      dd_nxt;
    logic [2:0]       iter;
    logic [11:0]      hum_res;
    logic [7:0]       t_op;
    logic [3:0]       f_op;
    logic             pending;
    logic [7:0]       p_h;
    logic [7:0]       p_t;
    logic [3:0]       p_f;
    logic [CNT_W-1:0] stale_cnt;
    logic [CNT_W-1:0] stale_nxt;
    logic [3:0]       frac_in;
    logic             good;
    logic [7:0]       ld_h;
    logic [7:0]       ld_t;
    logic [3:0]       ld_f;
    logic             hum_dec_unused;

    assign hum_dec_unused = ^humidity[7:0];
    assign good      = dht11_done && dht11_valid;
    assign frac_in   = (temperature[7:0] > 8'd9) ? 4'd9 : temperature[3:0];
    assign stale_nxt = (stale_cnt == LIM) ? stale_cnt : stale_cnt + CNT_W'(1);

    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5)
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    // A reading arriving on the COMMIT edge is newer than anything pending.
    always_comb begin
        ld_h = humidity[15:8];
        ld_t = temperature[15:8];
        ld_f = frac_in;
        if (state == COMMIT && !good) begin
            ld_h = p_h;
            ld_t = p_t;
            ld_f = p_f;
        end
        dd_nxt = dd_step(dd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dd         <= '0;
            iter       <= '0;
            hum_res    <= '0;
            t_op       <= '0;
            f_op       <= '0;
            pending    <= 1'b0;
            p_h        <= '0;
            p_t        <= '0;
            p_f        <= '0;
            stale_cnt  <= '0;
            hum_bcd    <= '0;
            temp_bcd   <= '0;
            temp_frac  <= '0;
            disp_valid <= 1'b0;
            upd_pulse  <= 1'b0;
            busy       <= 1'b0;
            stale      <= 1'b1;
            err_cnt    <= '0;
        end else begin
            upd_pulse <= 1'b0;
            stale_cnt <= stale_nxt;
            stale     <= !disp_valid || (stale_nxt == LIM);
            if (dht11_done && !dht11_valid && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (good && (state == CONV_H || state == CONV_T)) begin
                pending <= 1'b1;
                p_h     <= humidity[15:8];
                p_t     <= temperature[15:8];
                p_f     <= frac_in;
            end
            case (state)
                IDLE: begin
                    if (good) begin
                        dd    <= {12'd0, ld_h};
                        t_op  <= ld_t;
                        f_op  <= ld_f;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV_H;
                    end
                end
                CONV_H: begin
                    iter <= iter + 3'd1;
                    dd   <= dd_nxt;
                    if (iter == 3'd7) begin
                        hum_res <= dd_nxt[19:8];
                        dd      <= {12'd0, t_op};
                        state   <= CONV_T;
                    end
                end
                CONV_T: begin
                    iter <= iter + 3'd1;
                    dd   <= dd_nxt;
                    if (iter == 3'd7)
                        state <= COMMIT;
                end
                COMMIT: begin
                    hum_bcd    <= hum_res;
                    temp_bcd   <= dd[19:8];
                    temp_frac  <= f_op;
                    disp_valid <= 1'b1;
                    upd_pulse  <= 1'b1;
                    stale      <= 1'b0;
                    stale_cnt  <= '0;
                    if (good || pending) begin
                        dd      <= {12'd0, ld_h};
                        t_op    <= ld_t;
                        f_op    <= ld_f;
                        iter    <= '0;
                        pending <= 1'b0;
                        state   <= CONV_H;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_result_fmt.sv
// Directed bench for dht11_result_fmt with hand-computed BCD, latency, stale
// and error-count expectations.
module tb_dht11_result_fmt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] humidity = '0;
    logic [15:0] temperature = '0;
    logic        dht11_done = 1'b0;
    logic        dht11_valid = 1'b0;
    logic [11:0] hum_bcd;
    logic [11:0] temp_bcd;
    logic [3:0]  temp_frac;
    logic        disp_valid;
    logic        upd_pulse;
    logic        busy;
    logic        stale;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;

    dht11_result_fmt #(.CLK_FREQ(100), .STALE_SEC(1)) dut (
        .clk(clk), .rst_n(rst_n), .humidity(humidity), .temperature(temperature),
        .dht11_done(dht11_done), .dht11_valid(dht11_valid), .hum_bcd(hum_bcd),
        .temp_bcd(temp_bcd), .temp_frac(temp_frac), .disp_valid(disp_valid),
        .upd_pulse(upd_pulse), .busy(busy), .stale(stale), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(input logic [15:0] h, input logic [15:0] t);
        humidity = h; temperature = t; dht11_done = 1'b1; dht11_valid = 1'b1;
        tick();
        dht11_done = 1'b0; dht11_valid = 1'b0;
    endtask

    task automatic do_bad();
        dht11_done = 1'b1; dht11_valid = 1'b0;
        tick();
        dht11_done = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hum"}, hum_bcd, 0);
        chk({tag, "_temp"}, temp_bcd, 0);
        chk({tag, "_frac"}, temp_frac, 0);
        chk({tag, "_dv"}, disp_valid, 0);
        chk({tag, "_upd"}, upd_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stale"}, stale, 1);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    // Two good reads, the second `gap` edges after the first; both must publish in order.
    task automatic run_pair(input string tag, input logic [15:0] h1, input logic [15:0] h2,
                            input int gap, input logic [11:0] e1, input logic [11:0] e2);
        int n_upd;
        int drops;
        n_upd = 0;
        drops = 0;
        do_read(h1, 16'h1400);
        for (int i = 1; i <= 40; i++) begin
            if (i == gap) begin
                humidity = h2; temperature = 16'h1E03;
                dht11_done = 1'b1; dht11_valid = 1'b1;
            end
            tick();
            dht11_done = 1'b0; dht11_valid = 1'b0;
            if (upd_pulse) begin
                n_upd++;
                if (n_upd == 1) begin
                    chk({tag, "_first_hum"}, hum_bcd, e1);
                    chk({tag, "_first_at"}, i, 17);
                end else if (n_upd == 2) begin
                    chk({tag, "_second_hum"}, hum_bcd, e2);
                    chk({tag, "_second_temp"}, temp_bcd, 12'h030);
                    chk({tag, "_second_frac"}, temp_frac, 4'h3);
                    chk({tag, "_second_at"}, i, 34);
                end
            end else if (n_upd < 2 && !busy) begin
                drops++;
            end
        end
        chk({tag, "_n_upd"}, n_upd, 2);
        chk({tag, "_busy_drops"}, drops, 0);
    endtask

    initial begin
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 45 %RH, 26.5 degC
        do_read(16'h2D00, 16'h1A05);
        chk("t1_busy_e0", busy, 1);
        wait_cycles(16);
        chk("t1_no_upd_e16", upd_pulse, 0);
        chk("t1_hold_e16", hum_bcd, 0);
        tick();
        chk("t1_upd", upd_pulse, 1);
        chk("t1_hum", hum_bcd, 12'h045);
        chk("t1_temp", temp_bcd, 12'h026);
        chk("t1_frac", temp_frac, 4'h5);
        chk("t1_dv", disp_valid, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_stale", stale, 0);
        tick();
        chk("t1_upd_one", upd_pulse, 0);

        // commit was 2 edges ago counting this one; stale rises at commit+100
        wait_cycles(98);
        chk("stale_99", stale, 0);
        tick();
        chk("stale_100", stale, 1);
        do_bad();
        chk("stale_bad_keep", stale, 1);
        do_bad();
        do_bad();
        chk("err_3", err_cnt, 3);
        chk("err_hum_hold", hum_bcd, 12'h045);
        chk("err_upd", upd_pulse, 0);

        do_read(16'hFF00, 16'h000C);
        wait_cycles(17);
        chk("t2_upd", upd_pulse, 1);
        chk("t2_hum", hum_bcd, 12'h255);
        chk("t2_temp", temp_bcd, 12'h000);
        chk("t2_frac", temp_frac, 4'h9);
        tick();

        run_pair("gap5", 16'h2D00, 16'h3C00, 5, 12'h045, 12'h060);
        run_pair("gap17", 16'h0700, 16'h6400, 17, 12'h007, 12'h100);

        for (int i = 0; i < 260; i++) do_bad();
        chk("err_sat", err_cnt, 8'd255);

        // reset while in CONV_T
        do_read(16'h1100, 16'h2200);
        wait_cycles(12);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (upd_pulse) seen++;
            end
            chk("midrst_no_upd", seen, 0);
        end
        do_read(16'h6300, 16'h0907);
        wait_cycles(17);
        chk("post_upd", upd_pulse, 1);
        chk("post_hum", hum_bcd, 12'h099);
        chk("post_temp", temp_bcd, 12'h009);
        chk("post_frac", temp_frac, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
